// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter:
// FSM states, requester ids and the round-robin pick rule.
package dmem_port_arbiter_pkg;

  localparam int MEM_LAT_MAX = 8;
  localparam int LAT_CNT_W   = 3;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    REQ_CPU,
    REQ_DMA
  } req_id_t;

  function automatic req_id_t rr_pick(
    input logic    cpu,
    input logic    dma,
    input req_id_t last
  );
    if (cpu && dma)
      return (last == REQ_CPU) ? REQ_DMA : REQ_CPU;
    return cpu ? REQ_CPU : REQ_DMA;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr.sv
// Two-input round-robin pick with its last-grant pointer.
// Pointer moves only when a grant is actually taken.
module rr_arbiter2
  import dmem_port_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_cpu_req,
  input  logic    i_dma_req,
  input  logic    i_grant_en,
  output logic    o_valid,
  output req_id_t o_id
);

  req_id_t r_last;

  assign o_valid = i_cpu_req | i_dma_req;
  assign o_id    = rr_pick(i_cpu_req, i_dma_req, r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= REQ_DMA;
    end else if (i_grant_en && o_valid) begin
      r_last <= o_id;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port DataMemory between CPU and DMA:
// one transaction in flight, fixed-latency read return.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int DATA_W  = 19,
  parameter int ADDR_W  = 19,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("dmem_port_arbiter: MEM_LAT must be 1..8");
  end

  localparam logic [LAT_CNT_W-1:0] LAT_LAST =
    LAT_CNT_W'(MEM_LAT - 1);

  arb_state_t           r_state;
  req_id_t              r_owner;
  logic                 r_we;
  logic [LAT_CNT_W-1:0] r_lat;
  logic [DATA_W-1:0]    r_rdata;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_mem_wdata;
  logic                 r_mem_rd;
  logic                 r_mem_wr;
  logic                 r_cpu_gnt;
  logic                 r_dma_gnt;
  logic                 r_cpu_rvalid;
  logic                 r_dma_rvalid;

  logic                 w_grant_en;
  logic                 w_valid;
  req_id_t              w_pick;
  logic                 w_sel_dma;
  logic                 w_sel_we;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_wdata;

  assign w_grant_en  = (r_state == ARB_IDLE);
  assign w_sel_dma   = (w_pick == REQ_DMA);
  assign w_sel_we    = w_sel_dma ? dma_we    : cpu_we;
  assign w_sel_addr  = w_sel_dma ? dma_addr  : cpu_addr;
  assign w_sel_wdata = w_sel_dma ? dma_wdata : cpu_wdata;

  rr_arbiter2 u_rr (
    .clk        (clk),
    .rst_n      (reset),
    .i_cpu_req  (cpu_req),
    .i_dma_req  (dma_req),
    .i_grant_en (w_grant_en),
    .o_valid    (w_valid),
    .o_id       (w_pick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ARB_IDLE;
      r_owner      <= REQ_CPU;
      r_we         <= 1'b0;
      r_lat        <= '0;
      r_rdata      <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_cpu_gnt    <= 1'b0;
      r_dma_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_cpu_gnt    <= 1'b0;
      r_dma_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
      unique case (r_state)
        ARB_IDLE: begin
          if (w_valid) begin
            r_owner     <= w_pick;
            r_we        <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_wr    <= w_sel_we;
            r_mem_rd    <= ~w_sel_we;
            r_cpu_gnt   <= ~w_sel_dma;
            r_dma_gnt   <= w_sel_dma;
            r_state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          r_lat   <= '0;
          r_state <= r_we ? ARB_IDLE : ARB_WAIT;
        end
        ARB_WAIT: begin
          // mem_rdata is valid only in the last wait cycle
          if (r_lat == LAT_LAST) begin
            r_rdata      <= mem_rdata;
            r_cpu_rvalid <= (r_owner == REQ_CPU);
            r_dma_rvalid <= (r_owner == REQ_DMA);
            r_state      <= ARB_RESP;
          end else begin
            r_lat <= r_lat + LAT_CNT_W'(1);
          end
        end
        ARB_RESP: begin
          r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign cpu_gnt    = r_cpu_gnt;
  assign dma_gnt    = r_dma_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign dma_rvalid = r_dma_rvalid;
  assign cpu_rdata  = r_rdata;
  assign dma_rdata  = r_rdata;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_rd     = r_mem_rd;
  assign mem_wr     = r_mem_wr;
  assign busy       = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: memory model plus
// per-port issue/response scoreboards.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int DW  = 19;
  localparam int AW  = 19;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd, mem_wr, busy;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .MEM_LAT(LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_gnt   (dma_gnt),
    .dma_rvalid(dma_rvalid),
    .dma_rdata (dma_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // DataMemory model: read data appears LAT cycles after mem_rd
  logic [DW-1:0] mem  [256];
  logic [DW-1:0] rmem [256];
  logic [DW-1:0] pipe [LAT];

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
    pipe[0] <= mem_rd ? mem[mem_addr[7:0]] : '0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } op_t;
  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } rsp_t;

  op_t  cq[$], dq[$];
  rsp_t crq[$], drq[$];
  int   glog[$], gcyc[$];
  int   n_tests = 0, n_fail = 0, cyc = 0;
  op_t  mo;
  rsp_t mr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (reset) begin
    if (cpu_gnt) begin
      chk("gnt_excl", 32'(dma_gnt), 0);
      if (cq.size() == 0) chk("cpu_gnt_unexp", 1, 0);
      else begin
        mo = cq.pop_front();
        chk("cpu_addr", 32'(mem_addr), 32'(mo.a));
        chk("cpu_wr", 32'(mem_wr), 32'(mo.we));
        chk("cpu_rd", 32'(mem_rd), 32'(!mo.we));
        if (mo.we) begin
          chk("cpu_wdata", 32'(mem_wdata), 32'(mo.d));
          rmem[mo.a[7:0]] = mo.d;
        end else crq.push_back('{rmem[mo.a[7:0]], cyc + LAT + 1});
        glog.push_back(0);
        gcyc.push_back(cyc);
      end
    end
    if (dma_gnt) begin
      if (dq.size() == 0) chk("dma_gnt_unexp", 1, 0);
      else begin
        mo = dq.pop_front();
        chk("dma_addr", 32'(mem_addr), 32'(mo.a));
        chk("dma_wr", 32'(mem_wr), 32'(mo.we));
        chk("dma_rd", 32'(mem_rd), 32'(!mo.we));
        if (mo.we) begin
          chk("dma_wdata", 32'(mem_wdata), 32'(mo.d));
          rmem[mo.a[7:0]] = mo.d;
        end else drq.push_back('{rmem[mo.a[7:0]], cyc + LAT + 1});
        glog.push_back(1);
        gcyc.push_back(cyc);
      end
    end
    if (cpu_rvalid) begin
      chk("rvalid_excl", 32'(dma_rvalid), 0);
      if (crq.size() == 0) chk("cpu_rvalid_spur", 1, 0);
      else begin
        mr = crq.pop_front();
        chk("cpu_rdata", 32'(cpu_rdata), 32'(mr.d));
        chk("cpu_rlat", cyc, mr.c);
      end
    end
    if (dma_rvalid) begin
      if (drq.size() == 0) chk("dma_rvalid_spur", 1, 0);
      else begin
        mr = drq.pop_front();
        chk("dma_rdata", 32'(dma_rdata), 32'(mr.d));
        chk("dma_rlat", cyc, mr.c);
      end
    end
  end

  task automatic cpu_op(input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int w);
    cq.push_back('{we, a, d});
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    w = -1;
    for (int i = 0; i < 40 && w < 0; i++) begin
      @(negedge clk);
      if (cpu_gnt) w = i;
    end
    cpu_req = 1'b0;
    if (w < 0) begin
      chk("cpu_gnt_timeout", 0, 1);
      void'(cq.pop_back());
    end
  endtask

  task automatic dma_op(input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int w);
    dq.push_back('{we, a, d});
    dma_we = we; dma_addr = a; dma_wdata = d; dma_req = 1'b1;
    w = -1;
    for (int i = 0; i < 40 && w < 0; i++) begin
      @(negedge clk);
      if (dma_gnt) w = i;
    end
    dma_req = 1'b0;
    if (w < 0) begin
      chk("dma_gnt_timeout", 0, 1);
      void'(dq.pop_back());
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (crq.size() == 0 && drq.size() == 0 && !busy) break;
      @(negedge clk);
    end
    if (crq.size() + drq.size() != 0) begin
      chk("drain_timeout", crq.size() + drq.size(), 0);
      crq.delete(); drq.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  int w, gc;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = DW'(i * 37 + 5);
      rmem[i] = DW'(i * 37 + 5);
    end
    mem[8'h20]  = 19'h12345;
    rmem[8'h20] = 19'h12345;

    // 1: reset held, inputs toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      {cpu_req, cpu_we, dma_req, dma_we} = 4'($urandom);
      cpu_addr = AW'($urandom); dma_wdata = DW'($urandom);
      mem[i] = DW'(i * 37 + 5);
      #1;
      chk("rst_ctrl", 32'({cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
                           mem_rd, mem_wr, busy}), 0);
      chk("rst_data", 32'(mem_addr | mem_wdata | cpu_rdata | dma_rdata), 0);
    end
    {cpu_req, cpu_we, dma_req, dma_we} = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_busy", 32'(busy), 0);

    // 4: tie with writes from reset, CPU first
    glog.delete(); gcyc.delete();
    fork
      begin
        int wc;
        for (int i = 0; i < 3; i++) cpu_op(1, AW'(8'h40 + i), DW'(19'h111 * (i + 1)), wc);
      end
      begin
        int wd;
        for (int i = 0; i < 3; i++) dma_op(1, AW'(8'h50 + i), DW'(19'h222 * (i + 1)), wd);
      end
    join
    drain();
    chk("t4_ngrant", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++) begin
      chk("t4_order", glog[i], i % 2);
      if (i > 0) chk("t4_gap", gcyc[i] - gcyc[i-1], 2);
    end

    // 2: single CPU write
    @(negedge clk);
    cpu_op(1, 19'h00010, 19'h7FFFF, w);
    chk("t2_wait", w, 0);
    chk("t2_wr", 32'(mem_wr), 1);
    chk("t2_rd", 32'(mem_rd), 0);
    chk("t2_dgnt", 32'(dma_gnt), 0);
    chk("t2_addr", 32'(mem_addr), 32'h10);
    chk("t2_wdata", 32'(mem_wdata), 32'h7FFFF);
    chk("t2_busy", 32'(busy), 1);
    @(negedge clk);
    chk("t2_busy_lo", 32'(busy), 0);
    chk("t2_wr_lo", 32'(mem_wr), 0);
    chk("t2_addr_hold", 32'(mem_addr), 32'h10);

    // 3: DMA read, rvalid LAT+1 after gnt
    dma_op(0, 19'h00020, '0, w);
    gc = cyc;
    for (int i = 0; i < 10 && !dma_rvalid; i++) begin
      @(negedge clk);
      chk("t3_no_crv", 32'(cpu_rvalid), 0);
    end
    chk("t3_lat", cyc - gc, LAT + 1);
    chk("t3_rdata", 32'(dma_rdata), 32'h12345);
    chk("t3_shared", 32'(cpu_rdata), 32'h12345);
    drain();

    // 5: reset during CPU read wait
    cpu_op(0, 19'h00033, '0, w);
    @(negedge clk);
    chk("t5_busy", 32'(busy), 1);
    reset = 1'b0;
    crq.delete();
    repeat (2) @(negedge clk);
    chk("t5_rst_busy", 32'(busy), 0);
    reset = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    chk("t5_busy_after", 32'(busy), 0);
    dma_op(0, 19'h00041, '0, w);
    chk("t5_dma_wait", w, 0);
    drain();

    // 6: DMA arrives during CPU wait, wins next idle
    glog.delete(); gcyc.delete();
    fork
      begin
        int wc;
        cpu_op(0, 19'h00040, '0, wc);
        cpu_op(0, 19'h00050, '0, wc);
      end
      begin
        int wd;
        for (int i = 0; i < 40 && !cpu_gnt; i++) @(negedge clk);
        @(negedge clk);
        dma_op(0, 19'h00042, '0, wd);
      end
    join
    drain();
    chk("t6_ngrant", glog.size(), 3);
    if (glog.size() == 3) begin
      chk("t6_g0", glog[0], 0);
      chk("t6_g1", glog[1], 1);
      chk("t6_g2", glog[2], 0);
    end

    // mixed random traffic
    fork
      begin
        int wc;
        for (int i = 0; i < 6; i++)
          cpu_op(1'($urandom), AW'($urandom_range(128, 191)), DW'($urandom), wc);
      end
      begin
        int wd;
        for (int i = 0; i < 6; i++)
          dma_op(1'($urandom), AW'($urandom_range(160, 223)), DW'($urandom), wd);
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
